// File: rtl/servisia_boot_ctrl.sv
// servisia_boot_ctrl -- boot loader front end for a small core.
//
// After reset the controller takes a byte stream (3-byte little-endian
// length, the image bytes, then an optional checksum) and writes the image
// into SRAM starting at address 0. It then releases the core reset and hands
// the SRAM port to the core. When boot_skip_i is high in LEN0, loading is
// skipped and the core is released on the next edge.
//
// Build option: define SERVISIA_BOOT_VERIFY_EN to add a checksum byte after
// the image. The image is read back and summed mod 256. A mismatch ends in
// ERROR. With the macro undefined there is no checksum, sum or readback
// logic.
//
// Ports
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   rx_valid_i/rx_data_i    loader byte stream
//   rx_ready_o              byte accepted when rx_valid_i & rx_ready_o
//   boot_skip_i             skip loading, release core immediately
//   core_*_i                core SRAM requests (honoured only in RUN)
//   core_rdata_o            SRAM read data to core (0 outside RUN)
//   core_rst_no             registered active-low core reset
//   sram_*_o, sram_rdata_i  SRAM port (read data one cycle after read)
//   boot_done_o/boot_err_o  registered status flags
//
// state  | meaning
// LEN0   | wait for length[7:0] or boot_skip_i
// LEN1   | wait for length[15:8]
// LEN2   | wait for length[23:16], range-check length
// DATA   | write one image byte per accepted rx byte
// CSUM   | capture expected checksum (verify build only)
// VERIFY | read back image and accumulate sum (verify build only)
// RUN    | core owns SRAM, core out of reset (terminal)
// ERROR  | load failed, core held in reset (terminal)

module servisia_boot_ctrl #(
   parameter int aw = 20
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          rx_valid_i,
   input  logic [7:0]    rx_data_i,
   output logic          rx_ready_o,
   input  logic          boot_skip_i,
   input  logic [aw-1:0] core_waddr_i,
   input  logic [7:0]    core_wdata_i,
   input  logic          core_wen_i,
   input  logic [aw-1:0] core_raddr_i,
   input  logic          core_ren_i,
   output logic [7:0]    core_rdata_o,
   output logic          core_rst_no,
   output logic [aw-1:0] sram_addr_o,
   output logic [7:0]    sram_wdata_o,
   output logic          sram_write_o,
   output logic          sram_read_o,
   input  logic [7:0]    sram_rdata_i,
   output logic          boot_done_o,
   output logic          boot_err_o
);

   typedef enum logic [2:0] {
      LEN0 = 3'd0,
      LEN1,
      LEN2,
      DATA,
`ifdef SERVISIA_BOOT_VERIFY_EN
      CSUM,
      VERIFY,
`endif
      RUN,
      ERROR
   } state_e;

   localparam logic [24:0] MAX_LEN = 25'd1 << aw;

   state_e        state_q, state_d;
   logic [23:0]   len_q, len_d;
   logic [aw:0]   cnt_q, cnt_d;
   logic          core_rst_n_q, core_rst_n_d;
   logic          boot_done_q, boot_done_d;
   logic          boot_err_q, boot_err_d;
   logic          ready_st;
   logic [23:0]   len_full;
   logic [aw:0]   len_last;
`ifdef SERVISIA_BOOT_VERIFY_EN
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    sum_q, sum_d;
   logic          rd_pend_q, rd_pend_d;
   logic [7:0]    sum_next;
`endif

   assign len_full = {rx_data_i, len_q[15:0]};
   assign len_last = len_q[aw:0] - (aw+1)'(1);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      ready_st     = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_write_o = 1'b0;
      sram_read_o  = 1'b0;
      core_rdata_o = '0;
`ifdef SERVISIA_BOOT_VERIFY_EN
      csum_d       = csum_q;
      sum_d        = sum_q;
      rd_pend_d    = 1'b0;
      // Read data belongs to the read issued on the previous cycle.
      sum_next     = sum_q + (rd_pend_q ? sram_rdata_i : 8'h00);
`endif
      case (state_q)
         LEN0: begin
            ready_st = 1'b1;
            if (boot_skip_i) begin
               state_d = RUN;
            end else if (rx_valid_i) begin
               len_d[7:0] = rx_data_i;
               state_d    = LEN1;
            end
         end
         LEN1: begin
            ready_st = 1'b1;
            if (rx_valid_i) begin
               len_d[15:8] = rx_data_i;
               state_d     = LEN2;
            end
         end
         LEN2: begin
            ready_st = 1'b1;
            if (rx_valid_i) begin
               len_d = len_full;
               cnt_d = '0;
               if ({1'b0, len_full} > MAX_LEN) begin
                  state_d = ERROR;
               end else if (len_full == 24'd0) begin
`ifdef SERVISIA_BOOT_VERIFY_EN
                  state_d = CSUM;
`else
                  state_d = RUN;
`endif
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            ready_st = 1'b1;
            if (rx_valid_i) begin
               sram_write_o = 1'b1;
               sram_addr_o  = cnt_q[aw-1:0];
               sram_wdata_o = rx_data_i;
               cnt_d        = cnt_q + (aw+1)'(1);
               if (cnt_q == len_last) begin
`ifdef SERVISIA_BOOT_VERIFY_EN
                  state_d = CSUM;
`else
                  state_d = RUN;
`endif
               end
            end
         end
`ifdef SERVISIA_BOOT_VERIFY_EN
         CSUM: begin
            ready_st = 1'b1;
            if (rx_valid_i) begin
               csum_d  = rx_data_i;
               cnt_d   = '0;
               sum_d   = 8'h00;
               state_d = VERIFY;
            end
         end
         VERIFY: begin
            sum_d = sum_next;
            if (cnt_q != len_q[aw:0]) begin
               sram_read_o = 1'b1;
               sram_addr_o = cnt_q[aw-1:0];
               cnt_d       = cnt_q + (aw+1)'(1);
               rd_pend_d   = 1'b1;
            end else begin
               // All reads issued; sum_next already holds the last byte.
               state_d = (sum_next == csum_q) ? RUN : ERROR;
            end
         end
`endif
         RUN: begin
            sram_addr_o  = core_wen_i ? core_waddr_i : core_raddr_i;
            sram_wdata_o = core_wdata_i;
            sram_write_o = core_wen_i;
            // Write wins so the SRAM never sees both strobes at once.
            sram_read_o  = core_ren_i & ~core_wen_i;
            core_rdata_o = sram_rdata_i;
         end
         ERROR: begin
         end
         default: begin
            state_d = ERROR;
         end
      endcase
      core_rst_n_d = (state_d == RUN);
      boot_done_d  = (state_d == RUN);
      boot_err_d   = (state_d == ERROR);
   end

   // Keep the loader stalled while reset is held.
   assign rx_ready_o  = ready_st & rst_ni;
   assign core_rst_no = core_rst_n_q;
   assign boot_done_o = boot_done_q;
   assign boot_err_o  = boot_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= LEN0;
         len_q        <= '0;
         cnt_q        <= '0;
         core_rst_n_q <= 1'b0;
         boot_done_q  <= 1'b0;
         boot_err_q   <= 1'b0;
`ifdef SERVISIA_BOOT_VERIFY_EN
         csum_q       <= '0;
         sum_q        <= '0;
         rd_pend_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         core_rst_n_q <= core_rst_n_d;
         boot_done_q  <= boot_done_d;
         boot_err_q   <= boot_err_d;
`ifdef SERVISIA_BOOT_VERIFY_EN
         csum_q       <= csum_d;
         sum_q        <= sum_d;
         rd_pend_q    <= rd_pend_d;
`endif
      end
   end

endmodule

// File: doc/servisia_boot_ctrl.md
SERVISIA_BOOT_CTRL -- requirements
Module: servisia_boot_ctrl

Interface
REQ-001 Parameter: aw, default 20, SRAM byte-address width.
REQ-002 Port: clk_i, input, 1, system clock, all logic on rising edge.
REQ-003 Port: rst_ni, input, 1, asynchronous active-low reset.
REQ-004 Port: rx_valid_i / rx_data_i, input, 1 / 8, loader byte stream, valid strobe and data.
REQ-005 Port: rx_ready_o, output, 1, byte accepted on a cycle with rx_valid_i and rx_ready_o both high.
REQ-006 Port: boot_skip_i, input, 1, skip loading and release core immediately.
REQ-007 Port: core_waddr_i / core_wdata_i / core_wen_i / core_raddr_i / core_ren_i, inputs, aw / 8 / 1 / aw / 1, core SRAM requests.
REQ-008 Port: core_rdata_o, output, 8, SRAM read data to core.
REQ-009 Port: core_rst_no, output, 1, active-low core reset, registered.
REQ-010 Port: sram_addr_o / sram_wdata_o / sram_write_o / sram_read_o, outputs, aw / 8 / 1 / 1, SRAM request.
REQ-011 Port: sram_rdata_i, input, 8, SRAM read data, valid one cycle after sram_read_o.
REQ-012 Port: boot_done_o / boot_err_o, outputs, 1 / 1, status flags, registered.

Function
REQ-013 FSM states: LEN0, LEN1, LEN2, DATA, CSUM, VERIFY, RUN, ERROR.
REQ-014 LEN0: boot_skip_i high -> RUN next cycle; otherwise the accepted byte is length[7:0] -> LEN1.
REQ-015 LEN1 / LEN2: the accepted byte is length[15:8] / length[23:16]; LEN2 -> DATA.
REQ-016 At LEN2 exit: length > 2**aw -> ERROR; length == 0 -> CSUM (VERIFY compiled in) or RUN (VERIFY compiled out).
REQ-017 rx_ready_o is high in LEN0-LEN2, DATA and CSUM; low elsewhere; one byte per cycle, no bubbles.
REQ-018 DATA: accepted byte -> sram_write_o=1, sram_addr_o=counter, sram_wdata_o=byte, same cycle (combinational from rx_*); counter increments from 0.
REQ-019 DATA exit: when the byte at counter == length-1 is accepted -> CSUM (VERIFY compiled in) or RUN (VERIFY compiled out).
REQ-020 Counter width is aw+1 bits, so length == 2**aw never wraps the address.
REQ-021 RUN: sram_addr_o = core_wen_i ? core_waddr_i : core_raddr_i; write/read/wdata pass through combinationally; core_rdata_o = sram_rdata_i.
REQ-022 Outside RUN: core requests are ignored, core_rdata_o = 0, core_rst_no = 0.
REQ-023 Entering RUN: core_rst_no and boot_done_o go to 1 on the same edge; RUN is terminal until reset.
REQ-024 ERROR: terminal; boot_err_o = 1, core_rst_no = 0, no SRAM access.
REQ-025 sram_write_o and sram_read_o are never high in the same cycle.

Reset
REQ-026 rst_ni low -> state LEN0 immediately, counter and sum cleared; outputs: core_rst_no=0, boot_done_o=0, boot_err_o=0, sram_write_o=0, sram_read_o=0, rx_ready_o=0 while reset is asserted.
REQ-027 Reset mid-load discards partial progress; SRAM contents are not cleared.

Configuration
REQ-028 Macro SERVISIA_BOOT_VERIFY_EN defined: CSUM and VERIFY are present as specified in REQ-029 to REQ-031.
REQ-029 CSUM: the accepted byte is stored as expected checksum -> VERIFY.
REQ-030 VERIFY: one read per cycle, addresses 0..length-1 (sram_read_o=1); each sram_rdata_i is added mod 256 to sum one cycle later.
REQ-031 VERIFY exit: after the last read data is accumulated, sum == checksum -> RUN; mismatch -> ERROR.
REQ-032 Macro SERVISIA_BOOT_VERIFY_EN undefined: CSUM, VERIFY, the checksum register and the sum register are absent, and no readback occurs.

Verification
REQ-033 Skip: boot_skip_i=1 after reset -> core_rst_no=1, boot_done_o=1 within 1 cycle; core write addr 0x12345 data 0xA5 appears on SRAM pins.
REQ-034 Load: stream 04 00 00 11 22 33 44 (+ csum AA when VERIFY compiled in) -> writes 0x11..0x44 to addresses 0..3 on consecutive cycles, then RUN; with VERIFY, 4 reads occur, then boot_done_o=1.
REQ-035 Bad checksum (VERIFY compiled in): same stream with csum AB -> boot_err_o=1, core_rst_no stays 0, sram_write_o stays 0.
REQ-036 Oversize: length 0x100001 with aw=20 -> ERROR after the third byte, no SRAM write.
REQ-037 Zero length: stream 00 00 00 (+ csum 00 when VERIFY compiled in) -> RUN with no SRAM write or read.
REQ-038 Mid-load reset: assert rst_ni after 2 data bytes -> outputs at reset values; a reload of the full stream then completes normally.
